matmul_result_streamer: RTL and testbench
=========================================

MATMUL_RESULT_STREAMER -- requirements
Module: matmul_result_streamer

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- ACC_WIDTH, 32: signed width of each C element.
- OUT_WIDTH, 16: signed width of each streamed element; 2 <= OUT_WIDTH <= ACC_WIDTH.
- SATURATE, 1: 1 = clamp, 0 = truncate.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start_i, in, 1: capture mat_c_i and begin streaming.
- mat_c_i, in, N*M*ACC_WIDTH: result matrix; element (r,c) is at bits [(r*M+c)*ACC_WIDTH +: ACC_WIDTH].
- abort_i, in, 1: cancel the current stream.
- out_valid_o, out, 1: element valid.
- out_ready_i, in, 1: consumer ready.
- out_data_o, out, OUT_WIDTH: element value.
- out_row_o, out, max(1,$clog2(N)): row index.
- out_col_o, out, max(1,$clog2(M)): column index.
- out_last_o, out, 1: element (N-1,M-1).
- busy_o, out, 1: a stream is in progress.
- done_o, out, 1: one-cycle completion pulse.
- sat_cnt_o, out, 16: count of clamped elements in the current or last matrix.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and STREAM; busy_o SHALL be 1 exactly in STREAM.
REQ-005 In IDLE, start_i=1 at edge t SHALL register all of mat_c_i, enter STREAM, clear sat_cnt_o to 0, and present element (0,0) with out_valid_o=1 after edge t.
REQ-006 Elements SHALL be streamed row-major: (0,0),(0,1)..(0,M-1),(1,0)..(N-1,M-1); out_row_o and out_col_o SHALL match the presented element.
REQ-007 A transfer SHALL occur on an edge where out_valid_o=1 and out_ready_i=1.
REQ-008 While out_valid_o=1 and out_ready_i=0, out_data_o, out_row_o, out_col_o and out_last_o SHALL hold stable.
REQ-009 After a non-last transfer, the next element SHALL be presented in the next cycle with no bubble.
REQ-010 out_last_o SHALL be 1 only while element (N-1,M-1) is presented.
REQ-011 After the last transfer, the block SHALL drive out_valid_o=0 and busy_o=0, return to IDLE, and assert done_o for exactly one cycle.
REQ-012 start_i in the done_o cycle SHALL be accepted as in REQ-005.
REQ-013 start_i in STREAM SHALL be ignored; the captured matrix SHALL NOT change.
REQ-014 abort_i=1 in STREAM SHALL return the block to IDLE at the next edge with out_valid_o=0 and no done_o pulse; a handshake coinciding with abort completes at the bus, but streaming still stops.
REQ-015 abort_i=1 and start_i=1 together in IDLE SHALL be resolved in favour of abort: start is ignored.
REQ-016 With SATURATE=1, each element SHALL be clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-017 With SATURATE=0, the OUT_WIDTH LSBs SHALL be passed through and no clamping SHALL occur.
REQ-018 sat_cnt_o SHALL increment once per transferred element that was clamped, and SHALL saturate at 16'hFFFF.
REQ-019 sat_cnt_o SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-020 rst SHALL force IDLE and SHALL zero all outputs and the captured matrix at the next edge, including mid-stream; it has priority over start_i and abort_i.

Structure
REQ-021 N, M and the state enum typedef SHALL live in matmul_calc_pkg, which the block SHALL import.
REQ-022 The clamp/truncate logic SHALL be one combinational sub-module, matmul_sat_clip, parameterized by ACC_WIDTH, OUT_WIDTH and SATURATE, with an output flag indicating a clamp.

Verification
REQ-023 The bench SHALL use N=M=2, ACC_WIDTH=32, OUT_WIDTH=16 and SATURATE=1, and SHALL cover:
- C={1,2,3,4}, ready=1, start at edge 0 -> data 1,2,3,4 in cycles 1-4 with (r,c)=(0,0),(0,1),(1,0),(1,1); last in cycle 4; done_o in cycle 5 only.
- Same C, ready pattern 1,0,0,1,0,1,1 -> each value transferred once, in order, stable while stalled; done_o one cycle after the 4th transfer.
- C={70000,-70000,32767,-32768} -> 32767,-32768,32767,-32768; sat_cnt_o=2 after done.
- Abort after 2 transfers -> out_valid_o=0 next cycle, no done_o; a new start with C={5,6,7,8} streams 5,6,7,8 from (0,0), and sat_cnt_o restarts at 0.
- start with C={9,9,9,9} during a stream of {1,2,3,4} -> 1,2,3,4 delivered, and the second start is ignored.
- rst asserted after the first transfer -> all outputs 0 at the next edge; no done_o.

Source files
------------

// File: rtl/matmul_calc_pkg.sv
// Shared matrix dimensions and streamer state
// encoding for the matmul result path.
package matmul_calc_pkg;

  localparam int N = 2;
  localparam int M = 2;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

endpackage

// File: rtl/matmul_sat_clip.sv
// Narrows one signed accumulator value to the
// output width, by clamping or by truncation.
module matmul_sat_clip #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH-1:0] din_i,
  output logic [OUT_WIDTH-1:0] dout_o,
  output logic                 clipped_o
);

  if (SATURATE != 0) begin : g_sat
    logic [ACC_WIDTH-OUT_WIDTH:0] hi;
    logic                         fits;

    // Value fits when all bits above the
    // output sign bit replicate that sign.
    assign hi   = din_i[ACC_WIDTH-1:OUT_WIDTH-1];
    assign fits = (&hi) | (~|hi);

    always_comb begin
      dout_o    = din_i[OUT_WIDTH-1:0];
      clipped_o = 1'b0;
      if (!fits) begin
        clipped_o = 1'b1;
        if (din_i[ACC_WIDTH-1]) begin
          dout_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
          dout_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
      end
    end
  end else begin : g_trunc
    assign dout_o    = din_i[OUT_WIDTH-1:0];
    assign clipped_o = 1'b0;
  end

endmodule

// File: rtl/matmul_result_streamer.sv
// Captures an N x M result matrix and streams it
// row-major over a valid/ready bus.
module matmul_result_streamer
  import matmul_calc_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SATURATE  = 1,
  localparam int RW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [N*M*ACC_WIDTH-1:0]   mat_c_i,
  input  logic                       abort_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_WIDTH-1:0]       out_data_o,
  output logic [RW-1:0]              out_row_o,
  output logic [CW-1:0]              out_col_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [15:0]                sat_cnt_o
);

  localparam int NE = N * M;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  state_e                  state_q, state_d;
  logic [NE*ACC_WIDTH-1:0] mat_q, mat_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;
  logic                    done_q, done_d;

  logic [ACC_WIDTH-1:0]    elem;
  logic [OUT_WIDTH-1:0]    clip_data;
  logic                    clipped;
  logic                    busy;
  logic                    is_last;
  logic                    xfer;

  assign busy    = (state_q == STREAM);
  assign is_last = (idx_q == IW'(NE - 1));
  assign xfer    = busy & out_ready_i;
  assign elem    = mat_q[int'(idx_q)*ACC_WIDTH +: ACC_WIDTH];

  matmul_sat_clip #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SATURATE  (SATURATE)
  ) u_clip (
    .din_i     (elem),
    .dout_o    (clip_data),
    .clipped_o (clipped)
  );

  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    idx_d     = idx_q;
    sat_cnt_d = sat_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d   = STREAM;
          mat_d     = mat_c_i;
          idx_d     = '0;
          sat_cnt_d = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (clipped && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
          end
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = !abort_i;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        // A coincident handshake still counts,
        // but the stream ends here.
        if (abort_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mat_q     <= '0;
      idx_q     <= '0;
      sat_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      idx_q     <= idx_d;
      sat_cnt_q <= sat_cnt_d;
      done_q    <= done_d;
    end
  end

  assign out_valid_o = busy;
  assign busy_o      = busy;
  assign done_o      = done_q;
  assign sat_cnt_o   = sat_cnt_q;
  assign out_last_o  = busy & is_last;
  assign out_data_o  = busy ? clip_data : '0;
  assign out_row_o   = busy ? RW'(int'(idx_q) / M) : '0;
  assign out_col_o   = busy ? CW'(int'(idx_q) % M) : '0;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Vector table plus queue-based reference model
// for the matmul result streamer.
module tb_matmul_result_streamer;
  import matmul_calc_pkg::*;

  localparam int AW = 32;
  localparam int OW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              abort_i;
  logic              out_ready_i;
  logic [N*M*AW-1:0] mat_c_i;
  logic              out_valid_o;
  logic [OW-1:0]     out_data_o;
  logic [0:0]        out_row_o;
  logic [0:0]        out_col_o;
  logic              out_last_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       sat_cnt_o;

  matmul_result_streamer #(
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .SATURATE  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .mat_c_i     (mat_c_i),
    .abort_i     (abort_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_row_o   (out_row_o),
    .out_col_o   (out_col_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_cnt_o   (sat_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cm[4];

  typedef struct {
    int d;
    int r;
    int c;
    bit l;
    bit cl;
  } el_t;

  el_t q[$];
  bit  m_active;
  bit  m_done;
  bit  m_zero;
  int  m_cnt;

  typedef struct {
    bit st;
    bit rdy;
    bit v;
    int d;
    int r;
    int c;
    bit l;
    bit dn;
  } vec_t;

  vec_t tbl[6];

  function automatic void chk(
    string nm,
    logic signed [31:0] act,
    logic signed [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  function automatic el_t mk(int k);
    el_t e;
    int  v;
    v    = cm[k];
    e.cl = (v > 32767) || (v < -32768);
    e.d  = (v > 32767) ? 32767 :
           (v < -32768) ? -32768 : v;
    e.r  = k / M;
    e.c  = k % M;
    e.l  = (k == N*M-1);
    return e;
  endfunction

  // Called at a negedge: drive inputs, advance the
  // model, then land on the following negedge.
  task automatic step(bit st, bit ab, bit rdy, bit rs);
    el_t e;
    start_i     = st;
    abort_i     = ab;
    out_ready_i = rdy;
    rst         = rs;
    for (int k = 0; k < N*M; k++)
      mat_c_i[k*AW +: AW] = cm[k];
    m_zero = 1'b0;
    if (rs) begin
      q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
      m_zero   = 1'b1;
    end else if (m_active) begin
      m_done = 1'b0;
      if (rdy) begin
        e = q.pop_front();
        if (e.cl && m_cnt < 65535) m_cnt++;
        if (q.size() == 0) begin
          m_active = 1'b0;
          m_done   = !ab;
        end
      end
      if (ab) begin
        m_active = 1'b0;
        q.delete();
      end
    end else begin
      m_done = 1'b0;
      if (st && !ab) begin
        q.delete();
        for (int k = 0; k < N*M; k++)
          q.push_back(mk(k));
        m_cnt    = 0;
        m_active = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(string tag);
    chk({tag, ".valid"}, out_valid_o, m_active);
    chk({tag, ".busy"}, busy_o, m_active);
    chk({tag, ".done"}, done_o, m_done);
    chk({tag, ".sat"}, sat_cnt_o, m_cnt);
    if (m_active) begin
      chk({tag, ".data"}, $signed(out_data_o), q[0].d);
      chk({tag, ".row"}, out_row_o, q[0].r);
      chk({tag, ".col"}, out_col_o, q[0].c);
      chk({tag, ".last"}, out_last_o, q[0].l);
    end
    if (m_zero) begin
      chk({tag, ".z_data"}, out_data_o, 0);
      chk({tag, ".z_row"}, out_row_o, 0);
      chk({tag, ".z_col"}, out_col_o, 0);
      chk({tag, ".z_last"}, out_last_o, 0);
    end
  endtask

  task automatic run(bit st, bit ab, bit rdy,
                     bit rs, string tag);
    step(st, ab, rdy, rs);
    check_model(tag);
  endtask

  task automatic set_c(int a, int b, int c, int d);
    cm[0] = a;
    cm[1] = b;
    cm[2] = c;
    cm[3] = d;
  endtask

  function automatic int rnd_val();
    unique case ($urandom_range(0, 3))
      0: return $urandom_range(0, 200) - 100;
      1: return int'($urandom);
      2: return 32767 + $urandom_range(0, 2) - 1;
      default: return -32768 + $urandom_range(0, 2) - 1;
    endcase
  endfunction

  initial begin
    bit pat[7];
    tbl[0] = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 2, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 1, 3, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 4, 1, 1, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{0, 1, 0, 0, 0, 0, 0, 0};
    pat    = '{1, 0, 0, 1, 0, 1, 1};

    rst         = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    out_ready_i = 1'b0;
    mat_c_i     = '0;
    set_c(0, 0, 0, 0);
    @(negedge clk);
    run(0, 0, 1, 1, "reset");
    run(0, 0, 1, 0, "idle");

    set_c(1, 2, 3, 4);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].st, 0, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d.valid", i),
          out_valid_o, tbl[i].v);
      chk($sformatf("tbl%0d.busy", i),
          busy_o, tbl[i].v);
      chk($sformatf("tbl%0d.done", i),
          done_o, tbl[i].dn);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d.data", i),
            $signed(out_data_o), tbl[i].d);
        chk($sformatf("tbl%0d.row", i),
            out_row_o, tbl[i].r);
        chk($sformatf("tbl%0d.col", i),
            out_col_o, tbl[i].c);
        chk($sformatf("tbl%0d.last", i),
            out_last_o, tbl[i].l);
      end
    end

    run(1, 0, 0, 0, "stall.start");
    for (int i = 0; i < 7; i++)
      run(0, 0, pat[i], 0, "stall");
    run(0, 0, 0, 0, "stall.post");

    set_c(70000, -70000, 32767, -32768);
    run(1, 0, 1, 0, "sat.start");
    for (int i = 0; i < 4; i++)
      run(0, 0, 1, 0, "sat");
    chk("sat.cnt_after_done", sat_cnt_o, 2);
    run(0, 0, 1, 0, "sat.hold");

    set_c(1, 2, 3, 4);
    run(1, 0, 1, 0, "abort.start");
    run(0, 0, 1, 0, "abort.x1");
    run(0, 0, 1, 0, "abort.x2");
    run(0, 1, 0, 0, "abort");
    chk("abort.valid", out_valid_o, 0);
    run(0, 0, 1, 0, "abort.idle");
    chk("abort.no_done", done_o, 0);
    set_c(5, 6, 7, 8);
    run(1, 0, 1, 0, "restart");
    chk("restart.cnt", sat_cnt_o, 0);
    chk("restart.first", $signed(out_data_o), 5);
    for (int i = 0; i < 4; i++)
      run(0, 0, 1, 0, "restart.s");

    set_c(1, 2, 3, 4);
    run(1, 0, 1, 0, "ign.start");
    set_c(9, 9, 9, 9);
    run(1, 0, 1, 0, "ign.s1");
    run(1, 0, 1, 0, "ign.s2");
    chk("ign.data", $signed(out_data_o), 3);
    run(0, 0, 1, 0, "ign.s3");
    run(0, 0, 1, 0, "ign.done");

    set_c(1, 2, 3, 4);
    run(1, 0, 1, 0, "rst.start");
    run(0, 0, 1, 0, "rst.x1");
    run(0, 0, 1, 1, "rst.mid");
    run(0, 0, 1, 0, "rst.after");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < N*M; k++)
          cm[k] = rnd_val();
      end
      run($urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 96) == 0,
          "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
